// File: rtl/store_checker.sv
// Scoreboard on the data-memory write bus: checks each store, in order, against a
// programmed table of expected (address, data) pairs and reports sticky status.
module store_checker #(
  parameter int N       = 10,
  parameter int M       = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_idx,
  input  logic [N-1:0]               load_addr,
  input  logic [M-1:0]               load_data,
  input  logic [$clog2(DEPTH):0]     num_expected,
  input  logic                       start,
  input  logic                       memwr,
  input  logic [N-1:0]               addr,
  input  logic [M-1:0]               write_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     match_count,
  output logic [N-1:0]               err_addr,
  output logic [M-1:0]               err_data
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ARMED, PASSED, FAILED} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   tab_addr_q [DEPTH];
  logic [M-1:0]   tab_data_q [DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  mc_q, mc_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           to_q, to_d;
  logic [N-1:0]   ea_q, ea_d;
  logic [M-1:0]   ed_q, ed_d;
  logic [IW-1:0]  mc_idx;
  logic           hit;

  // Table is only writable while idle so a running check sees a stable image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
    end else if (state_q == IDLE && load_en) begin
      tab_addr_q[load_idx] <= load_addr;
      tab_data_q[load_idx] <= load_data;
    end
  end

  assign mc_idx = mc_q[IW-1:0];
  assign hit    = (addr == tab_addr_q[mc_idx]) && (write_data == tab_data_q[mc_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mc_q    <= '0;
      tmr_q   <= '0;
      to_q    <= 1'b0;
      ea_q    <= '0;
      ed_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      tmr_q   <= tmr_d;
      to_q    <= to_d;
      ea_q    <= ea_d;
      ed_q    <= ed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_d    = mc_q;
    tmr_d   = tmr_q;
    to_d    = to_q;
    ea_d    = ea_q;
    ed_d    = ed_q;
    if (start) begin
      // start wins over any store in the same cycle; that store is not checked
      cnt_d   = (num_expected > CW'(DEPTH)) ? CW'(DEPTH) : num_expected;
      mc_d    = '0;
      tmr_d   = '0;
      to_d    = 1'b0;
      ea_d    = '0;
      ed_d    = '0;
      state_d = (cnt_d == '0) ? PASSED : ARMED;
    end else if (state_q == ARMED) begin
      if (memwr) begin
        if (hit) begin
          mc_d  = mc_q + CW'(1);
          tmr_d = '0;
          if (mc_d == cnt_q) state_d = PASSED;
        end else begin
          state_d = FAILED;
          ea_d    = addr;
          ed_d    = write_data;
        end
      end else begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_d == TW'(TIMEOUT - 1)) begin
          state_d = FAILED;
          to_d    = 1'b1;
          ea_d    = '0;
          ed_d    = '0;
        end
      end
    end
  end

  assign busy        = (state_q == ARMED);
  assign done        = (state_q == PASSED) || (state_q == FAILED);
  assign pass        = (state_q == PASSED);
  assign fail        = (state_q == FAILED);
  assign timeout     = to_q;
  assign match_count = mc_q;
  assign err_addr    = ea_q;
  assign err_data    = ed_q;
endmodule
